// File: rtl/prefetch_ctrl_if.sv
// IMEM request/response port and fetch-FIFO push port of the prefetch controller.
// "master" is the controller side; "slave" is the IMEM/FIFO side.
interface prefetch_ctrl_if;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic [1:0]  fifo_free_i;
  logic        fifo_push_o;
  logic [31:0] fifo_wdata_o;
  logic        fifo_clear_o;
  logic        fifo_skip_lo_o;

  modport master (
    output instr_req_o, instr_addr_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  fifo_free_i,
    output fifo_push_o, fifo_wdata_o, fifo_clear_o, fifo_skip_lo_o
  );

  modport slave (
    input  instr_req_o, instr_addr_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output fifo_free_i,
    input  fifo_push_o, fifo_wdata_o, fifo_clear_o, fifo_skip_lo_o
  );
endinterface

// File: rtl/prefetch_ctrl.sv
// Instruction prefetch controller: owns the fetch PC, issues credited IMEM requests,
// pushes responses into the fetch FIFO and discards in-flight responses after a redirect.
module prefetch_ctrl #(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned FIFO_DEPTH      = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   fetch_en_i,
  input  logic                   branch_i,
  input  logic [31:0]            branch_addr_i,
  prefetch_ctrl_if.master        bus,
  output logic                   busy_o
);

  localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);
  localparam logic [1:0] DEPTH   = 2'(FIFO_DEPTH);

  typedef enum logic {IDLE, FETCH} state_e;

  state_e      state_q;
  logic [31:0] fetch_addr_q;
  logic [1:0]  out_cnt_q;
  logic [1:0]  disc_cnt_q;
  logic        skip_pend_q;

  logic [1:0]  kept_cnt;
  logic        credit_ok;
  logic        req;
  logic        accept;
  logic        push;
  logic [1:0]  out_cnt_d;
  logic        unused_addr_bit0;

  // Halfword alignment is carried by bit 1 only; bit 0 of the target never matters.
  assign unused_addr_bit0 = branch_addr_i[0];

  // Responses still destined for the FIFO must always fit in its registered free space.
  assign kept_cnt  = out_cnt_q - disc_cnt_q;
  assign credit_ok = fetch_en_i && (kept_cnt < bus.fifo_free_i) && (out_cnt_q < MAX_OUT);

  assign req       = (state_q == FETCH) && credit_ok && !branch_i;
  assign accept    = req && bus.instr_gnt_i;
  assign push      = bus.instr_rvalid_i && (disc_cnt_q == 2'd0) && !branch_i;
  assign out_cnt_d = out_cnt_q + {1'b0, accept} - {1'b0, bus.instr_rvalid_i};

  assign bus.instr_req_o    = req;
  assign bus.instr_addr_o   = fetch_addr_q;
  assign bus.fifo_push_o    = push;
  assign bus.fifo_wdata_o   = bus.instr_rdata_i;
  assign bus.fifo_clear_o   = branch_i;
  assign bus.fifo_skip_lo_o = push && skip_pend_q;
  assign busy_o             = (out_cnt_q != 2'd0) || (disc_cnt_q != 2'd0);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fetch_addr_q <= BOOT_ADDR;
      out_cnt_q    <= 2'd0;
      disc_cnt_q   <= 2'd0;
      skip_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (fetch_en_i)  state_q <= FETCH;
        FETCH:   if (!fetch_en_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      out_cnt_q <= out_cnt_d;

      if (branch_i) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        fetch_addr_q <= {branch_addr_i[31:2], 2'b00};
        skip_pend_q  <= branch_addr_i[1];
        disc_cnt_q   <= out_cnt_d;
      end else begin
        if (accept) fetch_addr_q <= fetch_addr_q + 32'd4;
        if (bus.instr_rvalid_i && (disc_cnt_q != 2'd0)) disc_cnt_q <= disc_cnt_q - 2'd1;
        if (push) skip_pend_q <= 1'b0;
      end
    end
  end

  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.instr_rvalid_i |-> (out_cnt_q != 2'd0));

  a_push_has_space: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.fifo_push_o |-> (bus.fifo_free_i != 2'd0));

  a_free_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.fifo_free_i <= DEPTH);

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Randomized bench for prefetch_ctrl: IMEM and FIFO environment models, a transaction-level
// reference of the fetch stream, and a scoreboard monitor checking every FIFO push.
module tb_prefetch_ctrl;
  localparam logic [31:0] BOOT  = 32'h0000_0080;
  localparam int          MAXO  = 2;
  localparam int          DEPTH = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_en_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        busy_o;

  prefetch_ctrl_if bus ();

  prefetch_ctrl #(
    .BOOT_ADDR       (BOOT),
    .MAX_OUTSTANDING (MAXO),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fetch_en_i    (fetch_en_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .bus           (bus.master),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          gcyc;
  } imem_req_t;

  typedef struct {
    logic [31:0] data;
    logic        skip;
  } exp_push_t;

  imem_req_t imem_q[$];
  exp_push_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference-model state: the fetch stream as seen from outside the block.
  logic [31:0] pc;
  int          epoch;
  logic        prev_en;
  logic        skip_pend;
  int          fifo_cnt;
  int          cyc;

  // Stimulus knobs (percent probabilities).
  int gnt_pct, rv_pct, pop_pct, br_pct, en_pct;
  logic        br_once;
  logic [31:0] br_once_addr;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(5))
      0:       t = 32'h0000_0200;
      1:       t = 32'h0000_0302;
      2:       t = 32'hFFFF_FFF8;
      3:       t = 32'hFFFF_FFFA;
      default: t = $urandom;
    endcase
    return t;
  endfunction

  task automatic reset_models();
    imem_q.delete();
    exp_q.delete();
    pc        = BOOT;
    epoch     = 0;
    prev_en   = 1'b0;
    skip_pend = 1'b0;
    fifo_cnt  = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_ni             = 1'b0;
    fetch_en_i         = 1'b0;
    branch_i           = 1'b0;
    branch_addr_i      = 32'h0;
    bus.instr_gnt_i    = 1'b0;
    bus.instr_rvalid_i = 1'b0;
    bus.instr_rdata_i  = 32'h0;
    bus.fifo_free_i    = 2'(DEPTH);
    #1;
    reset_models();
    check("rst_req",   32'(bus.instr_req_o),    32'd0);
    check("rst_addr",  bus.instr_addr_o,        BOOT);
    check("rst_push",  32'(bus.fifo_push_o),    32'd0);
    check("rst_clear", 32'(bus.fifo_clear_o),   32'd0);
    check("rst_skip",  32'(bus.fifo_skip_lo_o), 32'd0);
    check("rst_busy",  32'(busy_o),             32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic run_cycles(int n);
    for (int k = 0; k < n; k++) begin
      logic        resp, br, exp_req, exp_push, pop;
      int          kept;
      imem_req_t   r;
      @(negedge clk_i);
      fetch_en_i      = ($urandom_range(99) < en_pct);
      bus.instr_gnt_i = ($urandom_range(99) < gnt_pct);
      resp = (imem_q.size() > 0) && (imem_q[0].gcyc < cyc) && ($urandom_range(99) < rv_pct);
      bus.instr_rvalid_i = resp;
      bus.instr_rdata_i  = resp ? mem_word(imem_q[0].addr) : $urandom;
      bus.fifo_free_i    = 2'(DEPTH - fifo_cnt);
      br = br_once || ($urandom_range(99) < br_pct);
      branch_i      = br;
      branch_addr_i = br_once ? br_once_addr : (br ? pick_target() : $urandom);
      br_once = 1'b0;
      #1;

      kept = 0;
      foreach (imem_q[i]) if (imem_q[i].epoch == epoch) kept++;
      exp_req = prev_en && fetch_en_i && !br && (kept < DEPTH - fifo_cnt) && (imem_q.size() < MAXO);
      check("req",   32'(bus.instr_req_o),  32'(exp_req));
      check("clear", 32'(bus.fifo_clear_o), 32'(br));
      check("busy",  32'(busy_o),           32'(imem_q.size() != 0));

      exp_push = 1'b0;
      if (resp) begin
        r = imem_q.pop_front();
        if (r.epoch == epoch && !br) begin
          exp_push = 1'b1;
          exp_q.push_back('{data: mem_word(r.addr), skip: skip_pend});
          skip_pend = 1'b0;
        end
      end
      check("push", 32'(bus.fifo_push_o), 32'(exp_push));

      if (bus.instr_req_o && bus.instr_gnt_i) begin
        check("addr", bus.instr_addr_o, pc);
        imem_q.push_back('{addr: pc, epoch: epoch, gcyc: cyc});
        pc = pc + 32'd4;
      end

      if (br) begin
        epoch++;
        pc        = {branch_addr_i[31:2], 2'b00};
        skip_pend = branch_addr_i[1];
      end
      prev_en = fetch_en_i;

      if (br) fifo_cnt = 0;
      else begin
        pop = (fifo_cnt > 0) && ($urandom_range(99) < pop_pct);
        fifo_cnt = fifo_cnt + int'(bus.fifo_push_o) - int'(pop);
      end
      cyc++;
    end
  endtask

  // Scoreboard monitor: every push the DUT presents must match the next expected word.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni && bus.fifo_push_o) begin
        if (exp_q.size() == 0) begin
          check("push_unexpected", 32'd1, 32'd0);
        end else begin
          exp_push_t e;
          e = exp_q.pop_front();
          check("push_data", bus.fifo_wdata_o, e.data);
          check("push_skip", 32'(bus.fifo_skip_lo_o), 32'(e.skip));
        end
      end
    end
  end

  task automatic set_knobs(int g, int rv, int po, int b, int en);
    gnt_pct = g; rv_pct = rv; pop_pct = po; br_pct = b; en_pct = en;
  endtask

  task automatic redirect(logic [31:0] a);
    br_once      = 1'b1;
    br_once_addr = a;
    run_cycles(1);
  endtask

  initial begin
    cyc     = 0;
    br_once = 1'b0;
    rst_ni  = 1'b1;
    apply_reset();

    // Streaming from boot with an always-granting IMEM and a draining FIFO.
    set_knobs(100, 100, 100, 0, 100);
    run_cycles(20);

    // Directed redirects: aligned, misaligned and wrap-around targets.
    redirect(32'h0000_0200);
    run_cycles(12);
    redirect(32'h0000_0302);
    run_cycles(12);
    redirect(32'hFFFF_FFF8);
    run_cycles(12);

    // Grant withheld, then redirect with nothing outstanding.
    set_knobs(0, 100, 100, 0, 100);
    run_cycles(6);
    redirect(32'h0000_0400);
    set_knobs(100, 100, 100, 0, 100);
    run_cycles(8);

    // Random traffic with FIFO backpressure and frequent redirects.
    set_knobs(60, 50, 30, 5, 90);
    run_cycles(2000);
    set_knobs(80, 70, 5, 3, 95);
    run_cycles(800);
    set_knobs(20, 40, 50, 15, 70);
    run_cycles(800);

    // Reset in the middle of traffic.
    apply_reset();
    set_knobs(70, 60, 40, 20, 90);
    run_cycles(1000);

    // Drain: stop fetching and let all outstanding responses return.
    set_knobs(0, 100, 100, 0, 0);
    run_cycles(12);
    check("drain_outstanding", 32'(imem_q.size()), 32'd0);
    check("drain_scoreboard",  32'(exp_q.size()),  32'd0);
    check("drain_busy",        32'(busy_o),        32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
